selftest_harness: RTL and testbench

- Self-contained, self-checking top-level harness instantiated directly by the simulation driver.
- It writes a pseudo-random pattern into an internal scratch RAM, reads it back, and compares every word.
- It reports a pass on a single sticky success output.
- On a failure it never asserts success, so the driver's cycle-limit timeout reports the failure.

---
 rtl/selftest_harness_pkg.sv | 21 ++
 rtl/harness_scratch_ram.sv | 23 ++
 rtl/selftest_harness.sv | 99 +++++++++
 tb/tb_selftest_harness.sv | 103 ++++++++++
 4 files changed

// File: rtl/selftest_harness_pkg.sv
// Shared types and constants for the scratch-RAM self-test harness:
// FSM state encoding, LFSR taps/seed and the LFSR step function.
package selftest_harness_pkg;

  typedef enum logic [2:0] {
    WRITE = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2024;

  // Right-shifting Galois LFSR: feed the shifted-out bit back through the taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/harness_scratch_ram.sv
// Parameterised scratch RAM: one write port, one synchronous read port
// with a single cycle of latency. Contents are not reset.
module harness_scratch_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/selftest_harness.sv
// Self-checking harness: fills a scratch RAM with an LFSR pattern, reads it
// back, compares every word and raises a sticky io_success on a clean pass.
module selftest_harness
  import selftest_harness_pkg::*;
#(
  parameter int          ADDR_W     = 4,
  parameter logic [31:0] SEED       = DEFAULT_SEED,
  parameter int          FAULT_ADDR = -1
) (
  input  logic clock,
  input  logic reset,
  output logic io_success
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [31:0]       SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam bit                FAULT_EN  = (FAULT_ADDR >= 0) && (FAULT_ADDR < DEPTH);
  localparam logic [ADDR_W-1:0] FAULT_IDX = FAULT_EN ? ADDR_W'(FAULT_ADDR) : '0;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       lfsr;
  logic [31:0]       exp_word;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic [31:0]       wr_data;
  logic              fault_hit;
  logic              mismatch;
  logic              last_idx;

  assign last_idx  = (idx == LAST_IDX);
  assign fault_hit = FAULT_EN && (idx == FAULT_IDX);
  assign wr_data   = lfsr ^ {31'b0, fault_hit};
  // rd_data belongs to the read issued last cycle; exp_word was latched with it.
  assign mismatch  = rd_valid && (rd_data != exp_word);

  harness_scratch_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clock   (clock),
    .wr_en   (state == WRITE),
    .wr_addr (idx),
    .wr_data (wr_data),
    .rd_en   (state == READ),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      WRITE:   if (last_idx) state_next = READ;
      READ:    if (last_idx) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      default: state_next = state;
    endcase
    if (mismatch) state_next = FAIL;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= WRITE;
      idx        <= '0;
      lfsr       <= SEED_EFF;
      exp_word   <= '0;
      rd_valid   <= 1'b0;
      io_success <= 1'b0;
    end else begin
      state      <= state_next;
      // Registered from the next state so success appears on the DONE edge itself.
      io_success <= (state_next == DONE);
      rd_valid   <= (state == READ);
      case (state)
        WRITE: begin
          if (last_idx) begin
            idx  <= '0;
            lfsr <= SEED_EFF;
          end else begin
            idx  <= idx + 1'b1;
            lfsr <= lfsr_step(lfsr);
          end
        end
        READ: begin
          exp_word <= lfsr;
          lfsr     <= lfsr_step(lfsr);
          idx      <= last_idx ? '0 : idx + 1'b1;
        end
        default: begin
          idx  <= idx;
          lfsr <= lfsr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_selftest_harness.sv
// Bench for selftest_harness: four parameterisations share one clock/reset
// and are checked each edge against an edge-count model of the pass timing.
module tb_selftest_harness;
  import selftest_harness_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic succ_main, succ_fault, succ_seed0, succ_small;

  int vectors     = 0;
  int miscompares = 0;
  int since       = 0;  // rising edges with reset high since the last reset edge

  always #5 clock = ~clock;

  selftest_harness dut_main (
    .clock (clock), .reset (reset), .io_success (succ_main)
  );
  selftest_harness #(.FAULT_ADDR(5)) dut_fault (
    .clock (clock), .reset (reset), .io_success (succ_fault)
  );
  selftest_harness #(.SEED(32'h0)) dut_seed0 (
    .clock (clock), .reset (reset), .io_success (succ_seed0)
  );
  selftest_harness #(.ADDR_W(2)) dut_small (
    .clock (clock), .reset (reset), .io_success (succ_small)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, since, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, since, obs, exp);
    end
  endtask

  // Word k of the pattern: seed advanced k times by the Galois rule.
  function automatic logic [31:0] model_word(input logic [31:0] seed, input int k);
    logic [31:0] w;
    w = seed;
    for (int i = 0; i < k; i++) begin
      if (w[0]) w = (w >> 1) ^ 32'h8020_0003;
      else      w = w >> 1;
    end
    return w;
  endfunction

  // One clock edge with the given reset level, then check every instance.
  task automatic step(input logic rst_val);
    reset = rst_val;
    @(posedge clock);
    #1;
    if (!rst_val) since = 0;
    else          since++;
    chk1("main_success",  succ_main,  since >= 33);
    chk1("small_success", succ_small, since >= 9);
    chk1("seed0_success", succ_seed0, since >= 33);
    chk1("fault_success", succ_fault, 1'b0);
    if (since == 16) begin
      for (int k = 0; k < 16; k++)
        chk32($sformatf("main_ram[%0d]", k), dut_main.u_ram.mem[k],
              model_word(32'hACE1_2024, k));
      chk32("fault_ram[4]", dut_fault.u_ram.mem[4], model_word(32'hACE1_2024, 4));
      chk32("fault_ram[5]", dut_fault.u_ram.mem[5], model_word(32'hACE1_2024, 5) ^ 32'h1);
      chk32("seed0_ram[0]", dut_seed0.u_ram.mem[0], 32'h1);
      chk32("seed0_ram[1]", dut_seed0.u_ram.mem[1], 32'h8020_0003);
    end
    if (since == 22) chk1("fault_not_failed_yet", dut_fault.state == FAIL, 1'b0);
    if (since == 23) chk1("fault_failed_at_23",   dut_fault.state == FAIL, 1'b1);
    if (since == 0)  chk1("main_state_write",     dut_main.state == WRITE, 1'b1);
  endtask

  initial begin
    // Reset held low for five edges.
    repeat (5) step(1'b0);
    // Clean run / fault / seed-zero / small-depth, long enough to show stickiness.
    repeat (1000) step(1'b1);
    // Mid-run reset: edge 20 of a fresh run is low for two cycles.
    step(1'b0);
    repeat (19) step(1'b1);
    repeat (2) step(1'b0);
    repeat (40) step(1'b1);
    // Reset for a single cycle after a pass.
    step(1'b0);
    repeat (40) step(1'b1);
    // Randomised reset pulses at random points of the run.
    repeat (10) begin
      repeat ($urandom_range(1, 3)) step(1'b0);
      repeat ($urandom_range(5, 45)) step(1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
